// File: rtl/arb_pkg.sv
// Shared types and constants for the four-input round-robin arbiter.
package arb_pkg;

    // Number of requesters served by the arbiter.
    localparam int N_REQ = 4;

    // Encoded requester index, also used as the round-robin priority pointer.
    typedef logic [1:0] ptr_t;

    // Arbiter handshake states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } arbState_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: finds the first set request bit
// starting at the pointer position and wrapping around modulo four.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  ptr_t             ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output ptr_t             pick_idx_o
);

    ptr_t cand;
    logic found;

    // Scan ptr, ptr+1, ... (mod 4) and keep only the first requester seen.
    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        cand       = '0;
        found      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_i + ptr_t'(k);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                pick_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-input round-robin arbiter with a registered one-hot grant, a
// valid/ready acceptance handshake and a bounded busy hold with timeout.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 15
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             gnt_ready_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arbState_t        state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    ptr_t             ptr_q, ptr_d;
    ptr_t             winIdx_q, winIdx_d;
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] pick;
    ptr_t             pickIdx;
    logic             winReq;

    rr_pick4 uPick (
        .req_i      (req_i),
        .ptr_i      (ptr_q),
        .pick_o     (pick),
        .pick_idx_o (pickIdx)
    );

    assign winReq = req_i[winIdx_q];

    // State register plus grant, pointer, winner index, hold counter and timeout pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            winIdx_q  <= '0;
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            winIdx_q  <= winIdx_d;
            holdCnt_q <= holdCnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: offer the picked winner, accept on ready, release on withdrawal or timeout.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        winIdx_d  = winIdx_q;
        holdCnt_d = holdCnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d    = pick;
                    winIdx_d = pickIdx;
                    state_d  = OFFER;
                end else begin
                    gnt_d = '0;
                end
            end
            OFFER: begin
                if (gnt_ready_i) begin
                    state_d   = BUSY;
                    ptr_d     = winIdx_q + ptr_t'(1);
                    holdCnt_d = '0;
                end else if (!winReq) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!winReq) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (holdCnt_q == CNT_LAST) begin
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == OFFER);
    assign busy_o      = (state_q == BUSY);
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4, built with TIMEOUT=4.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       gntReady;
    logic [3:0] gnt;
    logic       gntValid;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.TIMEOUT(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .gnt_ready_i (gntReady),
        .gnt_o       (gnt),
        .gnt_valid_o (gntValid),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset for one edge with quiet inputs, then release.
    task automatic applyReset();
        rst = 1'b1; req = 4'b0000; gntReady = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    // Reset values of every output and of the priority pointer.
    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; gntReady = 1'b1;
        step(2);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
        checks++; if (gntValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", gntValid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got=%b want=0", timeout); end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("[TB] FAIL reset_ptr got=%0d want=0", dut.ptr_q); end
        rst = 1'b0; req = 4'b0000; gntReady = 1'b0;
        step(1);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL idle_noreq_gnt got=%b want=0000", gnt); end
    endtask

    // req=0101 with ready held: 0001, then 0100, then 0001 as the pointer rotates.
    task automatic test_rotation();
        applyReset();
        req = 4'b0101; gntReady = 1'b1;
        step(1);
        checks++; if (gnt !== 4'b0001 || gntValid !== 1'b1) begin errors++; $display("[TB] FAIL rot_offer0 gnt=%b valid=%b want 0001/1", gnt, gntValid); end
        step(1);
        checks++; if (busy !== 1'b1 || gntValid !== 1'b0 || gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rot_busy0 busy=%b valid=%b gnt=%b want 1/0/0001", busy, gntValid, gnt); end
        req = 4'b0100;
        step(1);
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rot_release0 gnt=%b busy=%b want 0000/0", gnt, busy); end
        req = 4'b0101;
        step(1);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL rot_offer2 gnt=%b want=0100", gnt); end
        step(1);
        req = 4'b0001;
        step(1);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rot_release2 gnt=%b want=0000", gnt); end
        req = 4'b0101;
        step(1);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rot_offer0_again gnt=%b want=0001", gnt); end
    endtask

    // All four requesting; each winner drops after three busy cycles.
    task automatic test_all_four();
        logic [3:0] expGnt;
        applyReset();
        req = 4'b1111; gntReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expGnt = 4'b0001 << (i % 4);
            step(1);
            checks++; if (gnt !== expGnt) begin errors++; $display("[TB] FAIL all4_offer%0d gnt=%b want=%b", i, gnt, expGnt); end
            step(1);
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL all4_busy%0d busy=%b want=1", i, busy); end
            step(2);
            req[i % 4] = 1'b0;
            step(1);
            checks++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL all4_release%0d gnt=%b timeout=%b want 0000/0", i, gnt, timeout); end
            req = 4'b1111;
        end
    endtask

    // Requester 2 offered, later arrivals do not preempt, withdrawal leaves the pointer alone.
    task automatic test_withdraw();
        applyReset();
        req = 4'b0001; gntReady = 1'b1;
        step(2);
        req = 4'b0000;
        step(1);
        gntReady = 1'b0; req = 4'b0100;
        step(1);
        checks++; if (gnt !== 4'b0100 || gntValid !== 1'b1) begin errors++; $display("[TB] FAIL wd_offer gnt=%b valid=%b want 0100/1", gnt, gntValid); end
        req = 4'b0101;
        step(2);
        checks++; if (gnt !== 4'b0100 || gntValid !== 1'b1) begin errors++; $display("[TB] FAIL wd_no_preempt gnt=%b valid=%b want 0100/1", gnt, gntValid); end
        req = 4'b0001;
        step(1);
        checks++; if (gnt !== 4'b0000 || gntValid !== 1'b0) begin errors++; $display("[TB] FAIL wd_idle gnt=%b valid=%b want 0000/0", gnt, gntValid); end
        checks++; if (dut.ptr_q !== 2'd1) begin errors++; $display("[TB] FAIL wd_ptr got=%0d want=1", dut.ptr_q); end
        req = 4'b1011;
        step(1);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL wd_reoffer gnt=%b want=0010", gnt); end
    endtask

    // Requester 3 holds forever: four busy cycles, then a one-cycle timeout, then requester 0.
    task automatic test_timeout();
        applyReset();
        req = 4'b1000; gntReady = 1'b1;
        step(1);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL to_offer gnt=%b want=1000", gnt); end
        step(1);
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            checks++; if (busy !== 1'b1 || gnt !== 4'b1000 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_hold%0d busy=%b gnt=%b timeout=%b want 1/1000/0", k, busy, gnt, timeout); end
            step(1);
        end
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_expire busy=%b gnt=%b timeout=%b want 0/0000/1", busy, gnt, timeout); end
        step(1);
        checks++; if (timeout !== 1'b0 || gnt !== 4'b0001) begin errors++; $display("[TB] FAIL to_next timeout=%b gnt=%b want 0/0001", timeout, gnt); end
    endtask

    // Ready and withdrawal in the same offer cycle: one busy cycle, no timeout.
    task automatic test_ready_withdraw();
        applyReset();
        req = 4'b0010; gntReady = 1'b0;
        step(1);
        checks++; if (gnt !== 4'b0010 || gntValid !== 1'b1) begin errors++; $display("[TB] FAIL rw_offer gnt=%b valid=%b want 0010/1", gnt, gntValid); end
        req = 4'b0000; gntReady = 1'b1;
        step(1);
        checks++; if (busy !== 1'b1 || gnt !== 4'b0010) begin errors++; $display("[TB] FAIL rw_busy busy=%b gnt=%b want 1/0010", busy, gnt); end
        step(1);
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL rw_idle busy=%b gnt=%b timeout=%b want 0/0000/0", busy, gnt, timeout); end
        step(1);
        checks++; if (timeout !== 1'b0 || gntValid !== 1'b0) begin errors++; $display("[TB] FAIL rw_quiet timeout=%b valid=%b want 0/0", timeout, gntValid); end
    endtask

    // Reset asserted during a busy hold clears everything, then arbitration restarts at requester 0.
    task automatic test_reset_mid_busy();
        applyReset();
        req = 4'b1111; gntReady = 1'b1;
        step(3);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rmb_busy busy=%b want=1", busy); end
        rst = 1'b1;
        step(1);
        checks++; if (gnt !== 4'b0000 || gntValid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL rmb_cleared gnt=%b valid=%b busy=%b timeout=%b want all 0", gnt, gntValid, busy, timeout); end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("[TB] FAIL rmb_ptr got=%0d want=0", dut.ptr_q); end
        rst = 1'b0;
        step(1);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rmb_restart gnt=%b want=0001", gnt); end
    endtask

    // Run every scenario in order and report.
    initial begin
        rst = 1'b1; req = 4'b0000; gntReady = 1'b0;
        #1;
        test_reset();
        test_rotation();
        test_all_four();
        test_withdraw();
        test_timeout();
        test_ready_withdraw();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
